// File: rtl/serial_rx.sv
// serial_rx: 8N1 serial receiver with a 2-flop synchronizer, mid-bit sampling
// and an optional "Hello, world! " message checker.
// Optional feature macro: SERIAL_RX_CHECK_EN (compiles in the message checker).
// Parameter CLKS_PER_BAUD: i_clk cycles per bit (>= 4).
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_rx         asynchronous serial input, idle high, LSB first
//   o_data       last correctly framed byte, held until the next one
//   o_valid      one-cycle pulse, o_data newly updated
//   o_frame_err  one-cycle pulse, stop bit sampled low
//   o_busy       receiver not in IDLE
//   o_mismatch   checker pulse: received byte differs from the message
//   o_msg_done   checker pulse: complete message received
module serial_rx #(
    parameter int CLKS_PER_BAUD = 104
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy,
    output logic       o_mismatch,
    output logic       o_msg_done
);

    localparam int CW = $clog2(CLKS_PER_BAUD);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BAUD - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BAUD / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          rx_s;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          ok_q, ok_d;
    logic          bad_q, bad_d;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          ferr_q;

    assign rx_s = sync2_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ok_q    <= 1'b0;
            bad_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ok_q    <= ok_d;
            bad_q   <= bad_d;
            // Stop-bit outcome is registered once more so the pulses land
            // one cycle after the mid-stop sample.
            valid_q <= ok_q;
            ferr_q  <= bad_q;
            if (ok_q) begin
                data_q <= shift_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        ok_d    = 1'b0;
        bad_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit gives half a bit of slack for
                // back-to-back frames.
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        ok_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = (state_q != IDLE);

`ifdef SERIAL_RX_CHECK_EN
    logic [3:0] idx_q;
    logic       mism_q;
    logic       done_q;

    function automatic logic [7:0] msg_byte(input logic [3:0] i);
        logic [7:0] b;
        unique case (i)
            4'd0:    b = 8'h48;
            4'd1:    b = 8'h65;
            4'd2:    b = 8'h6C;
            4'd3:    b = 8'h6C;
            4'd4:    b = 8'h6F;
            4'd5:    b = 8'h2C;
            4'd6:    b = 8'h20;
            4'd7:    b = 8'h77;
            4'd8:    b = 8'h6F;
            4'd9:    b = 8'h72;
            4'd10:   b = 8'h6C;
            4'd11:   b = 8'h64;
            4'd12:   b = 8'h21;
            4'd13:   b = 8'h20;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q  <= '0;
            mism_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            mism_q <= 1'b0;
            done_q <= 1'b0;
            if (valid_q) begin
                if (data_q == msg_byte(idx_q)) begin
                    if (idx_q == 4'd13) begin
                        idx_q  <= '0;
                        done_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end else begin
                    idx_q  <= '0;
                    mism_q <= 1'b1;
                end
            end else if (ferr_q) begin
                idx_q <= '0;
            end
        end
    end

    assign o_mismatch = mism_q;
    assign o_msg_done = done_q;
`else
    assign o_mismatch = 1'b0;
    assign o_msg_done = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: randomized and directed stimulus for serial_rx, checked each
// cycle against a frame-level model of the sampled serial line.
module tb_serial_rx;

    localparam int CPB  = 8;
    localparam int H    = CPB / 2;
    localparam int MAXN = 16384;
`ifdef SERIAL_RX_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;
    logic       o_mismatch;
    logic       o_msg_done;

    always #5 clk = ~clk;

    serial_rx #(.CLKS_PER_BAUD(CPB)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx       (rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frame_err(o_frame_err),
        .o_busy     (o_busy),
        .o_mismatch (o_mismatch),
        .o_msg_done (o_msg_done)
    );

    string MSG = "Hello, world! ";

    bit         line    [MAXN];
    bit         rst     [MAXN];
    bit         e_valid [MAXN];
    bit         e_ferr  [MAXN];
    bit         e_busy  [MAXN];
    bit         e_mism  [MAXN];
    bit         e_done  [MAXN];
    logic [7:0] e_vbyte [MAXN];
    logic [7:0] e_data  [MAXN];
    bit         ob_valid[MAXN];
    bit         ob_ferr [MAXN];
    bit         ob_busy [MAXN];
    bit         ob_mism [MAXN];
    bit         ob_done [MAXN];
    logic [7:0] ob_data [MAXN];

    int n = 0;
    int ncmp = 0;
    int nerr = 0;
    int midx = 0;

    task automatic cmp(input string nm, input int c,
                       input logic [15:0] act, input logic [15:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0d: got %0h want %0h", nm, c, act, exp);
        end
    endtask

    task automatic put(input bit v, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (n < MAXN) begin
                line[n] = v;
                rst[n]  = 1'b0;
                n++;
            end
        end
    endtask

    task automatic put_rst(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (n < MAXN) begin
                line[n] = 1'b1;
                rst[n]  = 1'b1;
                n++;
            end
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit stop);
        put(1'b0, CPB);
        for (int i = 0; i < 8; i++) put(b[i], CPB);
        put(stop, CPB);
    endtask

    function automatic bit effv(input int c);
        if (c >= n) return 1'b1;
        return rst[c] ? 1'b1 : line[c];
    endfunction

    function automatic int first_rst(input int a, input int b);
        for (int c = a; c <= b && c < n; c++) begin
            if (rst[c]) return c;
        end
        return -1;
    endfunction

    task automatic mark_busy(input int a, input int b);
        for (int c = a; c < b && c < n; c++) e_busy[c] = 1'b1;
    endtask

    task automatic chk_valid(input int v, input logic [7:0] b);
        if (CHK && v + 1 < n) begin
            if (b == MSG[midx]) begin
                if (midx == 13) begin
                    e_done[v+1] = 1'b1;
                    midx = 0;
                end else begin
                    midx++;
                end
            end else begin
                e_mism[v+1] = 1'b1;
                midx = 0;
            end
        end
    endtask

    // Frame-level model: walks the line as the receiver would see it
    // (index c = value sampled by the clock edge c), emitting events.
    task automatic run_model();
        int pos, t, s, e, r, j;
        logic [7:0] b, d;
        for (int c = 0; c < MAXN; c++) begin
            e_valid[c] = 0; e_ferr[c] = 0; e_busy[c] = 0;
            e_mism[c] = 0;  e_done[c] = 0; e_vbyte[c] = '0;
        end
        pos = 0;
        midx = 0;
        while (pos < n) begin
            if (rst[pos]) begin
                midx = 0;
                pos++;
                continue;
            end
            if (effv(pos)) begin
                pos++;
                continue;
            end
            t = pos;
            s = t + H + 9 * CPB;
            e = s + 2;
            if (effv(t + H)) begin
                r = first_rst(t + 1, t + 2 + H);
                if (r >= 0) begin
                    mark_busy(t + 2, r);
                    pos = r;
                end else begin
                    mark_busy(t + 2, t + 2 + H);
                    pos = t + H + 1;
                end
                continue;
            end
            r = first_rst(t + 1, e + 1);
            if (r >= 0) begin
                mark_busy(t + 2, r);
                pos = r;
                continue;
            end
            for (int k = 0; k < 8; k++) b[k] = effv(t + H + CPB * (k + 1));
            if (effv(s)) begin
                if (e + 1 < n) begin
                    e_valid[e+1] = 1'b1;
                    e_vbyte[e+1] = b;
                end
                chk_valid(e + 1, b);
                mark_busy(t + 2, e);
                pos = s + 1;
            end else begin
                if (e + 1 < n) e_ferr[e+1] = 1'b1;
                midx = 0;
                j = s + 1;
                while (j < n && !effv(j)) j++;
                if (j < n && rst[j]) begin
                    mark_busy(t + 2, j);
                    pos = j;
                end else begin
                    mark_busy(t + 2, j + 2);
                    pos = j + 1;
                end
            end
        end
        d = '0;
        for (int c = 0; c < n; c++) begin
            if (rst[c]) begin
                d = '0;
                e_mism[c] = 1'b0;
                e_done[c] = 1'b0;
            end
            if (e_valid[c]) d = e_vbyte[c];
            e_data[c] = d;
        end
    endtask

    function automatic int count(input int sel, input int a, input int b);
        int k = 0;
        for (int c = a; c < b && c < n; c++) begin
            case (sel)
                0: k += int'(ob_valid[c]);
                1: k += int'(ob_ferr[c]);
                2: k += int'(ob_mism[c]);
                3: k += int'(ob_done[c]);
                default: k += int'(ob_busy[c]);
            endcase
        end
        return k;
    endfunction

    int s1, s2, s3, s4, s5, s6, s7, lowend, r6;

    initial begin
        logic [7:0] rb;
        int kind, f0, off;
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        cmp("rst_outputs", -1,
            {o_data, o_valid, o_frame_err, o_busy, o_mismatch, o_msg_done},
            16'h0);

        put_rst(4);
        put(1'b1, 10);
        s1 = n;
        frame(8'hA5, 1'b1);
        put(1'b1, 12);
        s2 = n;
        frame(8'h3C, 1'b0);
        put(1'b0, 20);
        lowend = n;
        put(1'b1, 20);
        s3 = n;
        put(1'b0, 3);
        put(1'b1, 20);
        s4 = n;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 14; i++) frame(MSG[i], 1'b1);
        put(1'b1, 12);
        s5 = n;
        frame(8'h48, 1'b1);
        frame(8'h65, 1'b1);
        frame(8'h6C, 1'b1);
        frame(8'h70, 1'b1);
        for (int i = 0; i < 14; i++) frame(MSG[i], 1'b1);
        put(1'b1, 12);
        s6 = n;
        rb = 8'hC3;
        put(1'b0, CPB);
        for (int i = 0; i < 4; i++) put(rb[i], CPB);
        put(rb[4], 3);
        r6 = n;
        put_rst(5);
        put(1'b1, 25);
        frame(8'h55, 1'b1);
        put(1'b1, 12);
        s7 = n;
        for (int k = 0; k < 25; k++) begin
            kind = $urandom_range(0, 9);
            rb = 8'($urandom_range(0, 255));
            if (kind <= 5) begin
                frame(rb, 1'b1);
                put(1'b1, $urandom_range(0, 10));
            end else if (kind <= 7) begin
                frame(rb, 1'b0);
                put(1'b0, $urandom_range(0, 15));
                put(1'b1, $urandom_range(1, 12));
            end else if (kind == 8) begin
                put(1'b0, $urandom_range(1, 3));
                put(1'b1, $urandom_range(1, 10));
            end else begin
                f0 = n;
                frame(rb, 1'b1);
                off = $urandom_range(CPB, 9 * CPB);
                for (int i = 0; i < 3; i++) rst[f0+off+i] = 1'b1;
                put(1'b1, $urandom_range(1, 10));
            end
        end
        put(1'b1, 100);

        run_model();

        cmp("s1_model_lat", s1 + 79, 16'(e_valid[s1+79]), 16'h1);
        cmp("s1_model_byte", s1 + 79, 16'(e_vbyte[s1+79]), 16'hA5);

        @(posedge clk);
        #2;
        fork
            begin
                for (int c = 0; c < n; c++) begin
                    @(negedge clk);
                    rx    = line[c];
                    rst_n = !rst[c];
                    if (c > 0 && rst[c] && !rst[c-1]) begin
                        #1;
                        cmp("async_rst", c,
                            {o_data, o_valid, o_frame_err, o_busy,
                             o_mismatch, o_msg_done}, 16'h0);
                    end
                end
            end
            begin
                for (int c = 0; c < n; c++) begin
                    @(posedge clk);
                    #1;
                    ob_valid[c] = o_valid;
                    ob_ferr[c]  = o_frame_err;
                    ob_busy[c]  = o_busy;
                    ob_mism[c]  = o_mismatch;
                    ob_done[c]  = o_msg_done;
                    ob_data[c]  = o_data;
                    cmp("valid", c, 16'(o_valid), 16'(e_valid[c]));
                    cmp("frame_err", c, 16'(o_frame_err), 16'(e_ferr[c]));
                    cmp("busy", c, 16'(o_busy), 16'(e_busy[c]));
                    cmp("data", c, 16'(o_data), 16'(e_data[c]));
                    cmp("mismatch", c, 16'(o_mismatch), 16'(e_mism[c]));
                    cmp("msg_done", c, 16'(o_msg_done), 16'(e_done[c]));
                end
            end
        join

        cmp("s1_valid_cnt", s1, 16'(count(0, s1, s2)), 16'd1);
        cmp("s1_valid_at79", s1 + 79, 16'(ob_valid[s1+79]), 16'h1);
        cmp("s1_no_valid78", s1 + 78, 16'(ob_valid[s1+78]), 16'h0);
        cmp("s1_data", s1 + 79, 16'(ob_data[s1+79]), 16'hA5);
        cmp("s2_ferr_cnt", s2, 16'(count(1, s2, s3)), 16'd1);
        cmp("s2_valid_cnt", s2, 16'(count(0, s2, s3)), 16'd0);
        cmp("s2_data_kept", s3 - 1, 16'(ob_data[s3-1]), 16'hA5);
        cmp("s2_busy_held", s2, 16'(count(4, s2 + 2, lowend + 2)),
            16'(lowend - s2));
        cmp("s2_busy_drop", lowend + 2, 16'(ob_busy[lowend+2]), 16'h0);
        cmp("s3_pulses", s3, 16'(count(0, s3, s4) + count(1, s3, s4)), 16'd0);
        cmp("s3_idle", s4 - 1, 16'(ob_busy[s4-1]), 16'h0);
        cmp("s4_valid_cnt", s4, 16'(count(0, s4, s5)), 16'd28);
        cmp("s4_done_cnt", s4, 16'(count(3, s4, s5)), CHK ? 16'd2 : 16'd0);
        cmp("s4_mism_cnt", s4, 16'(count(2, s4, s5)), 16'd0);
        cmp("s5_valid_cnt", s5, 16'(count(0, s5, s6)), 16'd18);
        cmp("s5_mism_cnt", s5, 16'(count(2, s5, s6)), CHK ? 16'd1 : 16'd0);
        cmp("s5_done_cnt", s5, 16'(count(3, s5, s6)), CHK ? 16'd1 : 16'd0);
        cmp("s6_rst_data", r6, 16'(ob_data[r6]), 16'h0);
        cmp("s6_valid_cnt", s6, 16'(count(0, s6, s7)), 16'd1);
        cmp("s6_ferr_cnt", s6, 16'(count(1, s6, s7)), 16'd0);
        cmp("s6_data", s7 - 1, 16'(ob_data[s7-1]), 16'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 The module SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 The module SHALL have parameter CLKS_PER_BAUD, default 104, giving i_clk cycles per bit; legal values are at least 4.
REQ-003 Port i_clk  input  1  rising-edge clock for all state.
REQ-004 Port i_rst_n  input  1  asynchronous active-low reset.
REQ-005 Port i_rx  input  1  asynchronous serial line, 8N1 framing, idle high, LSB first.
REQ-006 Port o_data  output  8  last correctly framed byte, held until the next one.
REQ-007 Port o_valid  output  1  one-cycle pulse that marks o_data as newly updated.
REQ-008 Port o_frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-009 Port o_busy  output  1  high in every state except IDLE.
REQ-010 Port o_mismatch  output  1  one-cycle checker pulse (see Configuration).
REQ-011 Port o_msg_done  output  1  one-cycle checker pulse (see Configuration).

Function
REQ-012 i_rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all logic below uses the synchronized value rx_s.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-014 IDLE: when rx_s is sampled 0, the FSM SHALL go to START and clear the baud counter.
REQ-015 START: after CLKS_PER_BAUD/2 cycles (integer divide), rx_s is sampled at mid-bit:
  - 0: go to DATA.
  - 1: glitch; return to IDLE with no pulse.
REQ-016 DATA: the FSM SHALL sample 8 bits at intervals of CLKS_PER_BAUD cycles, shift them in LSB first, and go to STOP after bit 7.
REQ-017 STOP: after CLKS_PER_BAUD more cycles, rx_s is sampled:
  - 1: load o_data, pulse o_valid in the next cycle, go to IDLE.
  - 0: pulse o_frame_err in the next cycle, leave o_data unchanged, go to WAIT_IDLE.
REQ-018 WAIT_IDLE: the FSM SHALL stay until rx_s is 1, then go to IDLE; a falling edge is not accepted in the same cycle.
REQ-019 Latency: o_valid SHALL rise exactly 2 + CLKS_PER_BAUD/2 + 9*CLKS_PER_BAUD + 1 cycles after the first i_clk edge that samples i_rx low.
REQ-020 Back-to-back frames with no idle gap SHALL be received without loss, because STOP returns to IDLE at mid-stop-bit.
REQ-021 o_valid and o_frame_err SHALL never be high in the same cycle; neither pulse is ever longer than 1 cycle.
REQ-022 The baud counter SHALL count from 0 to CLKS_PER_BAUD-1 and be wide enough for the parameter value, with no overflow.

Reset
REQ-023 While i_rst_n is 0, all of the following SHALL hold immediately, regardless of the clock:
  - FSM in IDLE.
  - Synchronizer flops at 1.
  - o_data = 8'h00.
  - o_valid, o_frame_err, o_busy, o_mismatch and o_msg_done at 0.
  - Checker index at 0.
REQ-024 If reset is asserted mid-frame, the partial byte SHALL be discarded and no pulse emitted; after deassertion, reception restarts at the next falling edge.

Configuration
REQ-025 Macro SERIAL_RX_CHECK_EN SHALL compile in a message checker.
REQ-026 With the macro defined, the checker SHALL work as follows:
  - It holds a 4-bit index (0..13) into the 14-byte constant sequence "Hello, world! ".
  - On each o_valid, it compares o_data with entry[index].
  - On a match, index increments; a match at index 13 wraps index to 0 and pulses o_msg_done.
  - On a mismatch, o_mismatch pulses and index goes to 0.
  - o_frame_err also resets index to 0.
  - Both pulses occur in the cycle after o_valid.
REQ-027 With the macro undefined, the checker logic SHALL be absent and o_mismatch and o_msg_done tied to 0; ports are unchanged.

Verification
REQ-028 Benches SHALL use CLKS_PER_BAUD=8 and the following scenarios:
  1. Single frame 8'hA5 with a correct stop bit -> o_valid pulses once, o_data=8'hA5, exactly at the REQ-019 cycle (= 79 cycles).
  2. Stop bit forced low on byte 8'h3C, then line held low for 20 cycles -> one o_frame_err pulse, o_data keeps its prior value, o_busy stays high until rx returns to 1.
  3. 3-cycle low glitch on the idle line -> no o_valid, no o_frame_err, FSM back in IDLE.
  4. "Hello, world! " sent twice back-to-back with the macro defined -> 28 o_valid pulses, 2 o_msg_done pulses, 0 o_mismatch pulses.
  5. "Help" with the macro defined -> o_mismatch after 'p', index 0; then a full message -> one o_msg_done.
  6. i_rst_n pulsed low during data bit 4 -> outputs zero asynchronously, no pulse; the next frame 8'h55 is received correctly.
